fdiv_seq: RTL and testbench
===========================

# fdiv_seq

Sequencing controller for the iterative multiplicative (Goldschmidt) divide/sqrt unit. It accepts an operation request and steps the shared pipelined multiplier through the refinement iterations. It captures the quotient candidates (q0/q1/qm0/qm1/qp0/qp1), issues the remainder back-multiply that produces regr_out, and strobes the rounder's result register. It also holds the rounding configuration (rm, P) stable for the rounder for the whole operation.

## Interface
- MUL_LAT, 2: multiplier pipeline latency in cycles; legal range 1..7.
- DP_ITER, 4: refinement iterations for double precision; legal range 1..7.
- SP_ITER, 3: refinement iterations for single precision; legal range 1..7.

- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- op_sqrt  in  1  0 = divide, 1 = sqrt; latched on accept.
- P  in  1  1 = single, 0 = double; latched on accept.
- rm  in  3  rounding mode; latched on accept.
- special  in  1  special operand case (sel_inv != 0); sampled in LOAD.
- flush  in  1  abort current operation.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result register valid.
- ld_op  out  1  load operand registers and initial-approximation ROM.
- mul_en  out  1  issue a multiply this cycle.
- mul_sel  out  2  multiplier operand select: 01 = N*K, 10 = D*K, 11 = Q*D (remainder), 00 = idle.
- qreg_en  out  1  capture the quotient candidate registers.
- regr_en  out  1  capture the remainder register (regr_out).
- res_en  out  1  capture rounder Result/Flags.
- sqrt_q  out  1  latched op_sqrt.
- P_q  out  1  latched P.
- rm_q  out  3  latched rm.
- iter  out  3  completed-iteration count.

## Operation
- States: IDLE, LOAD, ISSUE_N, ISSUE_D, WAIT, QCAP, REM, WAIT_R, RCAP, ROUND, DONE.
- IDLE:
  - start & ~flush → LOAD.
  - On accept, latch sqrt_q, P_q and rm_q, and clear iter.
- LOAD: ld_op=1.
  - special → ROUND.
  - otherwise → ISSUE_N.
- ISSUE_N: mul_en=1, mul_sel=01 → ISSUE_D.
- ISSUE_D: mul_en=1, mul_sel=10 → WAIT.
- WAIT: lasts exactly MUL_LAT cycles, counted by an internal 3-bit wait counter. On its last cycle:
  - iter increments.
  - If the new iter equals NITER → QCAP; otherwise → ISSUE_N.
  - NITER = P_q ? SP_ITER : DP_ITER.
- QCAP: qreg_en=1 → REM.
- REM: mul_en=1, mul_sel=11 → WAIT_R.
- WAIT_R: lasts MUL_LAT cycles → RCAP.
- RCAP: regr_en=1 → ROUND.
- ROUND: res_en=1 → DONE.
- DONE: done=1 → IDLE.
  - start is ignored in DONE; it is accepted only in IDLE.
- Strobe exclusivity: at most one of ld_op, qreg_en, regr_en, res_en, done is high in any cycle.
- mul_sel = 00 and mul_en = 0 in every state except ISSUE_N, ISSUE_D and REM.
- sqrt_q, P_q and rm_q hold their values from accept until the next accept; they are unaffected by flush.
- iter saturates at NITER, holds its value through DONE, and clears only on the next accept.
- flush:
  - Any state → IDLE on the next edge; no done and no further strobes.
  - flush outranks start and every other transition in the same cycle.
- Special path: LOAD → ROUND → DONE. No multiplies are issued; qreg_en and regr_en stay 0.

## Timing
- Reset (reset_n low, asynchronous): state=IDLE and every output 0, including rm_q=000, P_q=0, sqrt_q=0 and iter=0.
- A reset asserted mid-operation aborts the operation immediately with no done pulse.
- Cycle numbering: cycle 0 is the edge at which start is sampled; LOAD is cycle 1.
- One iteration takes MUL_LAT+2 cycles.
- done cycle = 1 + NITER·(MUL_LAT+2) + MUL_LAT + 5.
  - Defaults, DP: done in cycle 24.
  - Defaults, SP: done in cycle 20.
  - Special path: done in cycle 3.
- DP default timeline:
  - Issues in cycles 2/3, 6/7, 10/11, 14/15.
  - QCAP 18, REM 19, RCAP 22, ROUND 23.
- busy rises in cycle 1 and falls after DONE. A new start is accepted at the earliest in the cycle after DONE.
- The outputs are Moore decodes of the registered state; there are no combinational paths from inputs to outputs.

## Test plan
- DP divide, P=0, rm=000, defaults:
  - mul_en high in cycles 2, 3, 6, 7, 10, 11, 14, 15 and 19; mul_sel pattern 01,10 per iteration, then 11.
  - qreg_en in cycle 18, regr_en in cycle 22, res_en in cycle 23, done in cycle 24; final iter=4.
- SP sqrt, P=1, rm=011: done in cycle 20, iter=3, P_q=1, rm_q=011, sqrt_q=1 held throughout.
- special=1 in LOAD: res_en in cycle 2, done in cycle 3, mul_en never high, qreg_en and regr_en never high.
- flush asserted in cycle 9 of a DP op: state is IDLE in cycle 10, busy=0, no done; a start in cycle 10 is accepted and the new op completes 24 cycles later.
- start held high continuously: back-to-back ops with one IDLE cycle between each DONE and the next LOAD; start asserted during DONE is not accepted.
- reset_n pulsed low asynchronously mid-WAIT: all outputs go to 0 immediately; after release a start runs a full, normal op.
- MUL_LAT=1, DP_ITER=2: done in cycle 1+2·3+1+5 = 13.

Source files
------------

// File: rtl/fdiv_seq.sv
`timescale 1ns/1ps
// fdiv_seq: sequencing controller for the Goldschmidt divide/sqrt unit.
// Drives the shared pipelined multiplier through NITER refinement
// iterations, captures the quotient candidates, issues the remainder
// back-multiply, strobes the rounder and holds rm/P/op for the rounder.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   start, op_sqrt, P, rm  operation request and its configuration
//   special                special-operand shortcut, sampled in LOAD
//   flush                  abort to IDLE on the next edge
//   busy, done             status; done is a one-cycle result-valid pulse
//   ld_op, qreg_en,        datapath capture strobes
//   regr_en, res_en
//   mul_en, mul_sel        multiplier issue and operand select
//   sqrt_q, P_q, rm_q      configuration latched on accept
//   iter                   completed-iteration count
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start
// LOAD     | load operands and initial approximation
// ISSUE_N  | issue N*K
// ISSUE_D  | issue D*K
// WAIT     | multiplier latency, iteration bookkeeping on last cycle
// QCAP     | capture quotient candidates
// REM      | issue Q*D remainder multiply
// WAIT_R   | multiplier latency for the remainder
// RCAP     | capture remainder
// ROUND    | capture rounder result/flags
// DONE     | result valid pulse
module fdiv_seq #(
    parameter int MUL_LAT = 2,
    parameter int DP_ITER = 4,
    parameter int SP_ITER = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       op_sqrt,
    input  logic       P,
    input  logic [2:0] rm,
    input  logic       special,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic       ld_op,
    output logic       mul_en,
    output logic [1:0] mul_sel,
    output logic       qreg_en,
    output logic       regr_en,
    output logic       res_en,
    output logic       sqrt_q,
    output logic       P_q,
    output logic [2:0] rm_q,
    output logic [2:0] iter
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_ISSUE_N, ST_ISSUE_D, ST_WAIT, ST_QCAP,
        ST_REM, ST_WAIT_R, ST_RCAP, ST_ROUND, ST_DONE
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(MUL_LAT - 1);
    localparam logic [2:0] DP_N      = 3'(DP_ITER);
    localparam logic [2:0] SP_N      = 3'(SP_ITER);

    state_t     state, state_nxt;
    logic [2:0] wait_cnt;
    logic [2:0] niter;
    logic [3:0] iter_inc;
    logic       wait_last;
    logic       accept;

    assign niter     = P_q ? SP_N : DP_N;
    // widened so a full 3-bit count cannot wrap in the compare
    assign iter_inc  = {1'b0, iter} + 4'd1;
    assign wait_last = (wait_cnt == 3'd0);
    assign accept    = (state == ST_IDLE) && start && !flush;

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        ld_op     = 1'b0;
        mul_en    = 1'b0;
        mul_sel   = 2'b00;
        qreg_en   = 1'b0;
        regr_en   = 1'b0;
        res_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                ld_op     = 1'b1;
                state_nxt = special ? ST_ROUND : ST_ISSUE_N;
            end
            ST_ISSUE_N: begin
                mul_en    = 1'b1;
                mul_sel   = 2'b01;
                state_nxt = ST_ISSUE_D;
            end
            ST_ISSUE_D: begin
                mul_en    = 1'b1;
                mul_sel   = 2'b10;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_last)
                    state_nxt = (iter_inc >= {1'b0, niter}) ? ST_QCAP : ST_ISSUE_N;
            end
            ST_QCAP: begin
                qreg_en   = 1'b1;
                state_nxt = ST_REM;
            end
            ST_REM: begin
                mul_en    = 1'b1;
                mul_sel   = 2'b11;
                state_nxt = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (wait_last) state_nxt = ST_RCAP;
            end
            ST_RCAP: begin
                regr_en   = 1'b1;
                state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                res_en    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            iter     <= 3'd0;
            sqrt_q   <= 1'b0;
            P_q      <= 1'b0;
            rm_q     <= 3'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sqrt_q <= op_sqrt;
                P_q    <= P;
                rm_q   <= rm;
                iter   <= 3'd0;
            end
            // down-counter armed while issuing, terminal count at zero
            if (state == ST_ISSUE_D || state == ST_REM)
                wait_cnt <= WAIT_INIT;
            else if ((state == ST_WAIT || state == ST_WAIT_R) && !wait_last)
                wait_cnt <= wait_cnt - 3'd1;
            if (state == ST_WAIT && wait_last && !flush && iter < niter)
                iter <= iter + 3'd1;
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
`timescale 1ns/1ps
module tb_fdiv_seq;

    localparam int L   = 2;
    localparam int DPN = 4;
    localparam int SPN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, op_sqrt, P, special, flush;
    logic [2:0] rm;
    logic       busy, done, ld_op, mul_en, qreg_en, regr_en, res_en, sqrt_q, P_q;
    logic [1:0] mul_sel;
    logic [2:0] rm_q, iter;

    logic       start2, P2, zero1;
    logic [2:0] zero3;
    logic       busy2, done2, ld_op2, mul_en2, qreg_en2, regr_en2, res_en2, sqrt_q2, P_q2;
    logic [1:0] mul_sel2;
    logic [2:0] rm_q2, iter2;

    fdiv_seq #(.MUL_LAT(L), .DP_ITER(DPN), .SP_ITER(SPN)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_sqrt(op_sqrt), .P(P), .rm(rm),
        .special(special), .flush(flush), .busy(busy), .done(done), .ld_op(ld_op),
        .mul_en(mul_en), .mul_sel(mul_sel), .qreg_en(qreg_en), .regr_en(regr_en),
        .res_en(res_en), .sqrt_q(sqrt_q), .P_q(P_q), .rm_q(rm_q), .iter(iter)
    );

    fdiv_seq #(.MUL_LAT(1), .DP_ITER(2), .SP_ITER(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op_sqrt(zero1), .P(P2), .rm(zero3),
        .special(zero1), .flush(zero1), .busy(busy2), .done(done2), .ld_op(ld_op2),
        .mul_en(mul_en2), .mul_sel(mul_sel2), .qreg_en(qreg_en2), .regr_en(regr_en2),
        .res_en(res_en2), .sqrt_q(sqrt_q2), .P_q(P_q2), .rm_q(rm_q2), .iter(iter2)
    );

    logic [16:0] outs;
    assign outs = {busy, done, ld_op, mul_en, mul_sel, qreg_en, regr_en, res_en,
                   sqrt_q, P_q, rm_q, iter};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-op behaviour: bit k of each mask = strobe high in cycle k
    // (cycle 1 = LOAD). end_cyc = bench cycle count when busy is first seen low.
    typedef struct packed {
        int          e0;
        int          end_cyc;
        int          done_rel;
        logic        expect_done;
        logic        check_detail;
        logic [127:0] ld, mul, lo, hi, qr, rg, rs, dn;
        logic [2:0]  iter;
        logic        sq;
        logic        p;
        logic [2:0]  rm;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] bitat(input int t);
        return 128'(1) << t;
    endfunction

    // Reference timeline: LOAD at 1, each iteration L+2 cycles starting at 2
    // (N then D issue, then L wait cycles), then QCAP, REM, L wait, RCAP, ROUND, DONE.
    function automatic exp_t model(input int e0, input logic sq, input logic p,
                                   input logic [2:0] r, input logic sp);
        exp_t x;
        int   n;
        int   t;
        x = '0;
        n = p ? SPN : DPN;
        x.e0 = e0;
        x.expect_done  = 1'b1;
        x.check_detail = 1'b1;
        x.sq = sq;
        x.p  = p;
        x.rm = r;
        x.ld = bitat(1);
        if (sp) begin
            x.rs = bitat(2);
            x.done_rel = 3;
            x.iter = 3'd0;
        end else begin
            for (int i = 0; i < n; i++) begin
                t = 2 + i * (L + 2);
                x.mul = x.mul | bitat(t) | bitat(t + 1);
                x.lo  = x.lo | bitat(t);
                x.hi  = x.hi | bitat(t + 1);
            end
            t = 1 + n * (L + 2);
            x.qr  = bitat(t + 1);
            x.mul = x.mul | bitat(t + 2);
            x.lo  = x.lo | bitat(t + 2);
            x.hi  = x.hi | bitat(t + 2);
            x.rg  = bitat(t + L + 3);
            x.rs  = bitat(t + L + 4);
            x.done_rel = t + L + 5;
            x.iter = 3'(n);
        end
        x.dn = bitat(x.done_rel);
        x.end_cyc = e0 + x.done_rel;
        return x;
    endfunction

    // ---------------- monitor ----------------
    logic [127:0] o_ld, o_mul, o_lo, o_hi, o_qr, o_rg, o_rs, o_dn;
    logic [2:0]   o_iter;
    logic         o_lat_bad;
    logic         m_prev_busy = 1'b0;
    int           m_rel;
    exp_t         m_x;

    task automatic clear_obs();
        o_ld = '0; o_mul = '0; o_lo = '0; o_hi = '0;
        o_qr = '0; o_rg = '0; o_rs = '0; o_dn = '0;
        o_iter = 3'd0; o_lat_bad = 1'b0;
    endtask

    initial clear_obs();

    always @(negedge clk) begin
        chk("strobe_exclusive", 128'($countones({ld_op, qreg_en, regr_en, res_en, done}) > 1), 128'(0));
        chk("mul_sel_idle", 128'(!mul_en && mul_sel != 2'b00), 128'(0));
        if (done && sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: got done=1 expected no operation pending (t=%0t)", $time);
        end
        if (sb.size() > 0) begin
            m_rel = cyc - sb[0].e0 + 1;
            if (m_rel >= 1 && m_rel < 128) begin
                o_ld  = o_ld  | (128'(ld_op)      << m_rel);
                o_mul = o_mul | (128'(mul_en)     << m_rel);
                o_lo  = o_lo  | (128'(mul_sel[0]) << m_rel);
                o_hi  = o_hi  | (128'(mul_sel[1]) << m_rel);
                o_qr  = o_qr  | (128'(qreg_en)    << m_rel);
                o_rg  = o_rg  | (128'(regr_en)    << m_rel);
                o_rs  = o_rs  | (128'(res_en)     << m_rel);
                o_dn  = o_dn  | (128'(done)       << m_rel);
                if (done) o_iter = iter;
                if (busy && {sqrt_q, P_q, rm_q} != {sb[0].sq, sb[0].p, sb[0].rm}) o_lat_bad = 1'b1;
            end
            if (!m_prev_busy && busy) chk("busy_rise_cycle", 128'(m_rel), 128'(1));
            if (m_prev_busy && !busy) begin
                m_x = sb.pop_front();
                chk("busy_fall_cycle", 128'(cyc), 128'(m_x.end_cyc));
                chk("done_seen", 128'(|o_dn), 128'(m_x.expect_done));
                if (m_x.check_detail) begin
                    chk("ld_op_cycles", o_ld, m_x.ld);
                    chk("mul_en_cycles", o_mul, m_x.mul);
                    chk("mul_sel0_cycles", o_lo, m_x.lo);
                    chk("mul_sel1_cycles", o_hi, m_x.hi);
                    chk("qreg_en_cycles", o_qr, m_x.qr);
                    chk("regr_en_cycles", o_rg, m_x.rg);
                    chk("res_en_cycles", o_rs, m_x.rs);
                    chk("done_cycles", o_dn, m_x.dn);
                    chk("iter_at_done", 128'(o_iter), 128'(m_x.iter));
                    chk("iter_held", 128'(iter), 128'(m_x.iter));
                    chk("cfg_latched", 128'(o_lat_bad), 128'(0));
                end
                clear_obs();
            end else if (cyc > sb[0].end_cyc + 3) begin
                m_x = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL op_timeout: got busy still high at cycle %0d expected idle by %0d", cyc, m_x.end_cyc);
                clear_obs();
            end
        end
        m_prev_busy = busy;
    end

    // ---------------- driver ----------------
    // Called on a negedge with the DUT idle; start is sampled at the next edge.
    task automatic issue(input logic sq, input logic p, input logic [2:0] r,
                         input logic sp, input int fc, input int rc);
        exp_t x;
        int   e0;
        int   rel;
        e0 = cyc + 1;
        x = model(e0, sq, p, r, sp);
        if (fc > 0) begin
            x.expect_done = 1'b0; x.check_detail = 1'b0; x.end_cyc = e0 + fc;
        end
        if (rc > 0) begin
            x.expect_done = 1'b0; x.check_detail = 1'b0; x.end_cyc = e0 + rc - 1;
        end
        sb.push_back(x);
        start = 1'b1; op_sqrt = sq; P = p; rm = r;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            op_sqrt = 1'($urandom); P = 1'($urandom); rm = 3'($urandom);
            rel = cyc - e0 + 1;
            special = (rel == 1) ? sp : 1'($urandom);
            flush = (fc > 0 && rel == fc);
            if (rc > 0 && rel == rc - 1) begin
                @(posedge clk);
                #2 reset_n = 1'b0;
                #1 chk("async_reset_outputs", 128'(outs), 128'(0));
                @(negedge clk);
                #2 reset_n = 1'b1;
                break;
            end
            if (cyc >= x.end_cyc) break;
        end
        flush = 1'b0;
        special = 1'b0;
    endtask

    task automatic run2(input logic p, input int exp_rel, input logic [2:0] exp_iter);
        int e0;
        int got;
        got = -1;
        @(negedge clk);
        e0 = cyc + 1;
        start2 = 1'b1; P2 = p;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) begin
                got = cyc - e0 + 1;
                break;
            end
        end
        chk("short_lat_done_cycle", 128'(got), 128'(exp_rel));
        chk("short_lat_iter", 128'(iter2), 128'(exp_iter));
    endtask

    logic       r_sq, r_p, r_sp;
    logic [2:0] r_rm;
    int         r_fc, r_gap, d, e0b;
    exp_t       tmp;

    initial begin
        reset_n = 1'b0; start = 1'b0; op_sqrt = 1'b0; P = 1'b0; rm = 3'd0;
        special = 1'b0; flush = 1'b0;
        start2 = 1'b0; P2 = 1'b0; zero1 = 1'b0; zero3 = 3'd0;
        #12;
        chk("reset_outputs", 128'(outs), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b0, 3'b000, 1'b0, 0, 0);   // DP divide
        issue(1'b1, 1'b1, 3'b011, 1'b0, 0, 0);   // SP sqrt
        @(negedge clk);
        issue(1'b0, 1'b0, 3'b010, 1'b1, 0, 0);   // special path
        issue(1'b0, 1'b0, 3'b001, 1'b0, 9, 0);   // flush in cycle 9
        issue(1'b1, 1'b0, 3'b110, 1'b0, 0, 0);   // start in cycle 10

        // start held high: back-to-back ops, one IDLE cycle between
        @(negedge clk);
        tmp = model(0, 1'b0, 1'b0, 3'b101, 1'b0);
        d = tmp.done_rel;
        e0b = cyc + 1;
        for (int k = 0; k < 3; k++) sb.push_back(model(e0b + k * (d + 1), 1'b0, 1'b0, 3'b101, 1'b0));
        start = 1'b1; op_sqrt = 1'b0; P = 1'b0; rm = 3'b101; special = 1'b0;
        for (int k = 0; k < 400 && cyc < e0b + 2 * (d + 1); k++) @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400 && cyc < e0b + 2 * (d + 1) + d; k++) @(negedge clk);

        issue(1'b0, 1'b1, 3'b111, 1'b0, 0, 5);   // async reset in cycle 5 (WAIT)
        issue(1'b0, 1'b0, 3'b000, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r_sq = 1'($urandom); r_p = 1'($urandom); r_rm = 3'($urandom);
            r_sp = ($urandom_range(0, 7) == 0);
            r_fc = 0;
            if ($urandom_range(0, 5) == 0) begin
                tmp = model(0, r_sq, r_p, r_rm, r_sp);
                r_fc = $urandom_range(1, tmp.done_rel - 1);
            end
            r_gap = $urandom_range(0, 3);
            repeat (r_gap) @(negedge clk);
            issue(r_sq, r_p, r_rm, r_sp, r_fc, 0);
        end

        for (int k = 0; k < 500 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        run2(1'b0, 13, 3'd2);
        run2(1'b1, 10, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
